// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump unit: FSM state encoding and
// default sizing constants used by the top level and its helpers.
package reg_dump_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_REGS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/lowest_bit_finder.sv
// Combinational priority finder: reports the index of the lowest set bit of
// vec_i and whether any bit is set at all. Index is 0 when nothing is set.
module lowest_bit_finder #(
    parameter int NUM_REGS    = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic [NUM_REGS-1:0]    vec_i,
    output logic [INDEX_WIDTH-1:0] index_o,
    output logic                   any_o
);

    logic [INDEX_WIDTH-1:0] index_s;
    logic                   any_s;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index_s = '0;
        any_s   = 1'b0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            index_s = vec_i[i] ? INDEX_WIDTH'(i) : index_s;
            any_s   = any_s | vec_i[i];
        end
    end

    assign index_o = index_s;
    assign any_o   = any_s;

endmodule

// File: rtl/reg_dump_unit.sv
// Register dump unit: walks a captured selection mask in ascending index
// order, reads each selected register through a combinational read port and
// streams it out on a valid/ready interface, flagging the final word.
// Optional feature: define REG_DUMP_PARITY_EN to add out_parity, the XOR
// reduction of out_data, registered alongside it.
module reg_dump_unit
    import reg_dump_pkg::*;
#(
    parameter int  DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int  NUM_REGS    = DEFAULT_NUM_REGS,
    localparam int INDEX_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_REGS-1:0]    mask,
    output logic [INDEX_WIDTH-1:0] read_index,
    input  logic [DATA_WIDTH-1:0]  read_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
`ifdef REG_DUMP_PARITY_EN
    ,
    output logic                   out_parity
`endif
);

    dump_state_e            state_q;
    logic [NUM_REGS-1:0]    rem_q;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [INDEX_WIDTH-1:0] out_index_q;
    logic                   out_last_q;
    logic                   busy_q;
    logic                   done_q;

    logic [INDEX_WIDTH-1:0] low_index_s;
    logic                   any_set_s;
    logic [NUM_REGS-1:0]    rem_d;
    logic [INDEX_WIDTH-1:0] read_index_s;

    lowest_bit_finder #(
        .NUM_REGS    (NUM_REGS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_finder (
        .vec_i   (rem_q),
        .index_o (low_index_s),
        .any_o   (any_set_s)
    );

    // Clearing the lowest set bit: x & (x - 1).
    assign rem_d = rem_q & (rem_q - NUM_REGS'(1));

    // Read port addresses the register being captured, parked at 0 otherwise.
    always_comb begin
        read_index_s = '0;
        if (state_q == ST_SCAN) begin
            read_index_s = low_index_s;
        end else begin
            read_index_s = '0;
        end
    end

`ifdef REG_DUMP_PARITY_EN
    logic out_parity_q;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    // Parity is captured on the same edge as the data word it covers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_parity_q <= 1'b0;
        end else if (state_q == ST_SCAN) begin
            out_parity_q <= even_parity(read_data);
        end else begin
            out_parity_q <= out_parity_q;
        end
    end

    assign out_parity = out_parity_q;
`endif

    // Dump sequencer: state plus all registered stream/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        rem_q  <= mask;
                        busy_q <= 1'b1;
                        if (mask != '0) begin
                            state_q <= ST_SCAN;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (any_set_s) begin
                        out_data_q  <= read_data;
                        out_index_q <= low_index_s;
                        out_last_q  <= (rem_d == '0);
                        rem_q       <= rem_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_SEND;
                    end else begin
                        // Unreachable with a consistent mask; fail safe to DONE.
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (rem_q != '0) begin
                            state_q <= ST_SCAN;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rem_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign read_index = read_index_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_index  = out_index_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit: table of dump masks with expected
// word sequences, plus directed backpressure, reset and parity sequences.
module tb_reg_dump_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mask;
    logic [1:0]  read_index;
    logic [15:0] read_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef REG_DUMP_PARITY_EN
    logic        out_parity;
`endif

    logic [15:0] regs [4];
    int          n_cmp  = 0;
    int          n_fail = 0;

    assign read_data = regs[read_index];

    always #5 clk = ~clk;

    reg_dump_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mask       (mask),
        .read_index (read_index),
        .read_data  (read_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
`ifdef REG_DUMP_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    typedef struct packed {
        logic [3:0]  m;
        logic [2:0]  n;
        logic [7:0]  idxs;   // word w index at [2w +: 2]
        logic [63:0] datas;  // word w data  at [16w +: 16]
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Full dump with out_ready held high; checks latency, order and done.
    task automatic run_dump(input string tag, input logic [3:0] m, input int n,
                            input logic [7:0] idxs, input logic [63:0] datas);
        start = 1'b1; mask = m; out_ready = 1'b1;
        tick();
        start = 1'b0; mask = ~m;   // later mask changes must have no effect
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        check({tag, " no valid after start"}, 32'(out_valid), 32'd0);
        if (n == 0) begin
            check({tag, " done"}, 32'(done), 32'd1);
            tick();
            check({tag, " done drop"}, 32'(done), 32'd0);
            check({tag, " busy drop"}, 32'(busy), 32'd0);
            check({tag, " still no valid"}, 32'(out_valid), 32'd0);
        end else begin
            for (int w = 0; w < n; w++) begin
                check($sformatf("%s rd_idx w%0d", tag, w), 32'(read_index), 32'(idxs[2*w +: 2]));
                tick();
                check($sformatf("%s valid w%0d", tag, w), 32'(out_valid), 32'd1);
                check($sformatf("%s data w%0d", tag, w), 32'(out_data), 32'(datas[16*w +: 16]));
                check($sformatf("%s index w%0d", tag, w), 32'(out_index), 32'(idxs[2*w +: 2]));
                check($sformatf("%s last w%0d", tag, w), 32'(out_last), (w == n - 1) ? 32'd1 : 32'd0);
                check($sformatf("%s rd_idx0 w%0d", tag, w), 32'(read_index), 32'd0);
                check($sformatf("%s no done w%0d", tag, w), 32'(done), 32'd0);
                tick();
                check($sformatf("%s valid drop w%0d", tag, w), 32'(out_valid), 32'd0);
            end
            check({tag, " done"}, 32'(done), 32'd1);
            check({tag, " busy in done"}, 32'(busy), 32'd1);
            tick();
            check({tag, " done drop"}, 32'(done), 32'd0);
            check({tag, " busy drop"}, 32'(busy), 32'd0);
        end
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{m: 4'b1111, n: 3'd4, idxs: 8'b11_10_01_00, datas: 64'h4444_3333_2222_1111};
        vecs[1] = '{m: 4'b1010, n: 3'd2, idxs: 8'b00_00_11_01, datas: 64'h0000_0000_4444_2222};
        vecs[2] = '{m: 4'b0001, n: 3'd1, idxs: 8'b00_00_00_00, datas: 64'h0000_0000_0000_1111};
        vecs[3] = '{m: 4'b1000, n: 3'd1, idxs: 8'b00_00_00_11, datas: 64'h0000_0000_0000_4444};
        vecs[4] = '{m: 4'b0110, n: 3'd2, idxs: 8'b00_00_10_01, datas: 64'h0000_0000_3333_2222};
        vecs[5] = '{m: 4'b0000, n: 3'd0, idxs: 8'b00_00_00_00, datas: 64'h0000_0000_0000_0000};

        regs[0] = 16'h1111; regs[1] = 16'h2222; regs[2] = 16'h3333; regs[3] = 16'h4444;
        reset = 1'b1; start = 1'b0; mask = 4'b0000; out_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_index", 32'(out_index), 32'd0);
        check("rst out_last", 32'(out_last), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst read_index", 32'(read_index), 32'd0);
        reset = 1'b0;
        tick();

        // Table-driven dumps
        for (int v = 0; v < 6; v++) begin
            run_dump($sformatf("vec%0d", v), vecs[v].m, int'(vecs[v].n), vecs[v].idxs, vecs[v].datas);
            tick();
        end

        // Backpressure on the first word with start pulses during the dump
        start = 1'b1; mask = 4'b1111; out_ready = 1'b0;
        tick();
        mask = 4'b0001;
        tick();
        for (int c = 0; c < 5; c++) begin
            start = c[0];
            check($sformatf("bp valid c%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp data c%0d", c), 32'(out_data), 32'h1111);
            check($sformatf("bp index c%0d", c), 32'(out_index), 32'd0);
            check($sformatf("bp last c%0d", c), 32'(out_last), 32'd0);
            tick();
        end
        out_ready = 1'b1; start = 1'b1;
        for (int w = 1; w < 4; w++) begin
            tick();
            check($sformatf("bp scan valid w%0d", w), 32'(out_valid), 32'd0);
            check($sformatf("bp rd_idx w%0d", w), 32'(read_index), 32'(w));
            tick();
            check($sformatf("bp data w%0d", w), 32'(out_data), 32'(regs[w]));
            check($sformatf("bp index w%0d", w), 32'(out_index), 32'(w));
            check($sformatf("bp last w%0d", w), 32'(out_last), (w == 3) ? 32'd1 : 32'd0);
        end
        start = 1'b0;
        tick();
        check("bp done", 32'(done), 32'd1);
        tick();
        check("bp idle busy", 32'(busy), 32'd0);
        check("bp idle done", 32'(done), 32'd0);
        tick();
        check("bp stays idle", 32'(busy), 32'd0);

        // Reset while the second word is pending
        start = 1'b1; mask = 4'b1111; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        check("mid pending valid", 32'(out_valid), 32'd1);
        check("mid pending index", 32'(out_index), 32'd1);
        reset = 1'b1;
        tick();
        check("mid rst valid", 32'(out_valid), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst data", 32'(out_data), 32'd0);
        check("mid rst last", 32'(out_last), 32'd0);
        reset = 1'b0; out_ready = 1'b1;
        tick();
        check("post rst valid a", 32'(out_valid), 32'd0);
        tick();
        check("post rst valid b", 32'(out_valid), 32'd0);
        check("post rst busy", 32'(busy), 32'd0);
        run_dump("after_rst", 4'b0100, 1, 8'b00_00_00_10, 64'h0000_0000_0000_3333);
        tick();

`ifdef REG_DUMP_PARITY_EN
        // Parity of captured words
        regs[0] = 16'h0007; regs[1] = 16'h0003;
        start = 1'b1; mask = 4'b0001; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        check("par data 0007", 32'(out_data), 32'h0007);
        check("par bit 0007", 32'(out_parity), 32'd1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        start = 1'b1; mask = 4'b0010; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        check("par data 0003", 32'(out_data), 32'h0003);
        check("par bit 0003", 32'(out_parity), 32'd0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        regs[0] = 16'h1111; regs[1] = 16'h2222;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
